// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 VGA timing constants, raster counter types and the sync decode.
// Latency: none (types, constants and a pure function).
// Backpressure: none; renderers import this to stay aligned with the raster generator.
package vga_sync_gen_pkg;

  // Counter compares are 10-bit unsigned, so H_TOTAL and V_TOTAL must each be <= 1024.
  localparam int CNT_W = 10;

  // System clocks per pixel: 100 MHz system clock -> 25 MHz pixel rate.
  localparam int CLK_DIV_DEF = 4;

  // Horizontal timing, in pixels.
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  // Vertical timing, in lines.
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Inclusive sync windows: hsync low on 656..751, vsync low on 490..491.
  localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Decoded per-pixel outputs that must track the raster position exactly.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // Value of the decode at position (0,0): both syncs idle, picture area active.
  localparam sync_t SYNC_RESET = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1};

  // Syncs are active-low inside their inclusive windows; video_on covers the visible area.
  function automatic sync_t sync_decode(
    input cnt_t h,
    input cnt_t v,
    input cnt_t h_disp,
    input cnt_t h_ss,
    input cnt_t h_se,
    input cnt_t v_disp,
    input cnt_t v_ss,
    input cnt_t v_se
  );
    sync_t s;
    s.hsync    = !((h >= h_ss) && (h <= h_se));
    s.vsync    = !((v >= v_ss) && (v <= v_se));
    s.video_on = (h < h_disp) && (v < v_disp);
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to renderers, RGB mux and monitor pins.
// Latency: none (wires only).
// Backpressure: none; consumers follow the raster and cannot stall it.
interface vga_sync_gen_if;
  import vga_sync_gen_pkg::*;

  cnt_t HCount;
  cnt_t VCount;
  logic hsync;
  logic vsync;
  logic video_on;
  logic pixel_tick;
  logic frame_start;

  // Driven by the raster generator.
  modport master (
    output HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
  );

  // Observed by renderers and the output stage.
  modport slave (
    input HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Pixel-rate strobe: divides the system clock by CLK_DIV (legal 2..16).
// Latency: first strobe on the CLK_DIV-th clock after reset release, then every CLK_DIV clocks.
// Backpressure: none; free-running.
module vga_sync_gen_pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Count 0..CLK_DIV-1 and wrap.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  // Divider register; reset realigns the pixel phase to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pixel_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing: H/V counters, active-low syncs, video_on, tick and frame strobes.
// Latency: counters advance on the edge after pixel_tick; decodes align with the current count.
// Backpressure: none. SYNC_OUT_REG_EN selects flopped (glitch-free) vs combinational decodes.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_DISP = cnt_t'(H_DISPLAY);
  localparam cnt_t V_DISP = cnt_t'(V_DISPLAY);
  localparam cnt_t H_SS   = cnt_t'(H_DISPLAY + H_FRONT);
  localparam cnt_t H_SE   = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam cnt_t V_SS   = cnt_t'(V_DISPLAY + V_FRONT);
  localparam cnt_t V_SE   = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic  pixel_tick;
  cnt_t  h_q;
  cnt_t  h_d;
  cnt_t  v_q;
  cnt_t  v_d;
  sync_t sync_cur;

  vga_sync_gen_pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_div (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick)
  );

  // Next raster position: one pixel per tick, line wrap steps the line, last line wraps the frame.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixel_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + cnt_t'(1);
        end
      end else begin
        h_d = h_q + cnt_t'(1);
      end
    end
  end

  // Raster position registers; reset restarts at (0,0) and wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

`ifdef SYNC_OUT_REG_EN
  sync_t sync_q;
  sync_t sync_d;

  // Decode the position the counters are about to load so the flops land in step with them.
  always_comb begin
    sync_d = sync_decode(h_d, v_d, H_DISP, H_SS, H_SE, V_DISP, V_SS, V_SE);
  end

  // Sync/video flops; the reset value equals the decode of (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= SYNC_RESET;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_cur = sync_q;
`else
  // Direct decode of the current position; may glitch between edges.
  always_comb begin
    sync_cur = sync_decode(h_q, v_q, H_DISP, H_SS, H_SE, V_DISP, V_SS, V_SE);
  end
`endif

  assign vga.HCount      = h_q;
  assign vga.VCount      = v_q;
  assign vga.hsync       = sync_cur.hsync;
  assign vga.vsync       = sync_cur.vsync;
  assign vga.video_on    = sync_cur.video_on;
  assign vga.pixel_tick  = pixel_tick;
  assign vga.frame_start = pixel_tick & (h_q == H_LAST) & (v_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: full-size timing instance for line-level behaviour, a scaled
// instance (same RTL, small geometry) for whole-frame behaviour within a short run.
// Expected outputs come from an absolute-time raster model queued ahead of each edge.
module tb_vga_sync_gen;
  import vga_sync_gen_pkg::*;

  localparam int B_DIV = 2;
  localparam int B_HD  = 16;
  localparam int B_HF  = 2;
  localparam int B_HS  = 3;
  localparam int B_HB  = 3;
  localparam int B_VD  = 6;
  localparam int B_VF  = 1;
  localparam int B_VS  = 2;
  localparam int B_VB  = 2;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic       tick;
    logic       fs;
  } obs_t;

  localparam obs_t RST_OBS = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1,
                               tick: 1'b0, fs: 1'b0};

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_a   = 0;
  int   n_b   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb_q[$];
  obs_t act_a;
  obs_t act_b;

  vga_sync_gen_if vif_a ();
  vga_sync_gen_if vif_b ();

  vga_sync_gen u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (vif_a)
  );

  vga_sync_gen #(
    .CLK_DIV   (B_DIV),
    .H_DISPLAY (B_HD), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
    .V_DISPLAY (B_VD), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (vif_b)
  );

  assign act_a = {vif_a.HCount, vif_a.VCount, vif_a.hsync, vif_a.vsync,
                  vif_a.video_on, vif_a.pixel_tick, vif_a.frame_start};
  assign act_b = {vif_b.HCount, vif_b.VCount, vif_b.hsync, vif_b.vsync,
                  vif_b.video_on, vif_b.pixel_tick, vif_b.frame_start};

  always #5 clk = ~clk;

  // Clocks elapsed since each instance left reset.
  always @(posedge clk) begin
    n_a <= rst_a ? 0 : n_a + 1;
    n_b <= rst_b ? 0 : n_b + 1;
  end

  // Raster state after n clocks out of reset, derived from absolute time.
  function automatic obs_t model(int n, int cd, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb);
    int   ht, vt, p, h, v;
    obs_t o;
    ht     = hd + hf + hs + hb;
    vt     = vd + vf + vs + vb;
    p      = n / cd;
    h      = p % ht;
    v      = (p / ht) % vt;
    o.h    = 10'(h);
    o.v    = 10'(v);
    o.tick = ((n % cd) == (cd - 1));
    o.hs   = !((h >= hd + hf) && (h < hd + hf + hs));
    o.vs   = !((v >= vd + vf) && (v < vd + vf + vs));
    o.von  = (h < hd) && (v < vd);
    o.fs   = o.tick && (h == ht - 1) && (v == vt - 1);
    return o;
  endfunction

  function automatic obs_t model_a(int n);
    return model(n, CLK_DIV_DEF, H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF,
                 V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
  endfunction

  function automatic obs_t model_b(int n);
    return model(n, B_DIV, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB);
  endfunction

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_a !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset_state_a: got %h, expected %h", act_a, RST_OBS);
    end
    n_checks++;
    if (act_b !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset_state_b: got %h, expected %h", act_b, RST_OBS);
    end
  endtask

  task automatic test_first_tick();
    obs_t e;
    int   first = -1;
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(model_a(n_a + 1));
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (act_a !== e) begin
        n_fail++;
        $display("FAIL first_tick_trace n=%0d: got %h, expected %h", n_a, act_a, e);
      end
      if (act_a.tick && first < 0) first = n_a;
      if (n_a == 4) begin
        n_checks++;
        if (act_a.h !== 10'd1) begin
          n_fail++;
          $display("FAIL hcount_after_first_tick: got %0d, expected 1", act_a.h);
        end
      end
    end
    n_checks++;
    if (first !== 3) begin
      n_fail++;
      $display("FAIL first_tick_clk: got clk %0d, expected clk 4", first + 1);
    end
  endtask

  task automatic test_line_scan();
    obs_t e;
    int   hs_ticks = 0;
    int   von_ticks = 0;
    int   hmin = 9999;
    int   hmax = -1;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 3199; i++) begin
      sb_q.push_back(model_a(n_a + 1));
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (act_a !== e) begin
        n_fail++;
        $display("FAIL line_scan_trace n=%0d: got %h, expected %h", n_a, act_a, e);
      end
      if (act_a.tick && act_a.v == 10'd0) begin
        if (!act_a.hs) begin
          hs_ticks++;
          if (int'(act_a.h) < hmin) hmin = int'(act_a.h);
          if (int'(act_a.h) > hmax) hmax = int'(act_a.h);
        end
        if (act_a.von) von_ticks++;
      end
    end
    n_checks++;
    if (hs_ticks !== 96) begin
      n_fail++;
      $display("FAIL hsync_low_ticks: got %0d, expected 96", hs_ticks);
    end
    n_checks++;
    if (hmin !== 656 || hmax !== 751) begin
      n_fail++;
      $display("FAIL hsync_window: got %0d..%0d, expected 656..751", hmin, hmax);
    end
    n_checks++;
    if (von_ticks !== 640) begin
      n_fail++;
      $display("FAIL video_on_ticks: got %0d, expected 640", von_ticks);
    end
  endtask

  task automatic test_line_wrap();
    obs_t e;
    n_checks++;
    if (act_a.h !== 10'd799 || act_a.v !== 10'd0 || act_a.tick !== 1'b1 || act_a.fs !== 1'b0) begin
      n_fail++;
      $display("FAIL line_end_state: got h=%0d v=%0d tick=%b fs=%b, expected h=799 v=0 tick=1 fs=0",
               act_a.h, act_a.v, act_a.tick, act_a.fs);
    end
    sb_q.push_back(model_a(n_a + 1));
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++;
    if (act_a !== e) begin
      n_fail++;
      $display("FAIL line_wrap_trace: got %h, expected %h", act_a, e);
    end
    n_checks++;
    if (act_a.h !== 10'd0 || act_a.v !== 10'd1 || act_a.fs !== 1'b0) begin
      n_fail++;
      $display("FAIL line_wrap: got h=%0d v=%0d fs=%b, expected h=0 v=1 fs=0",
               act_a.h, act_a.v, act_a.fs);
    end
  endtask

  task automatic test_frame();
    obs_t e;
    int   fs_cnt = 0;
    int   fs_first = -1;
    int   fs_second = -1;
    int   vmin = 9999;
    int   vmax = -1;
    int   von_bad = 0;
    rst_b = 1'b0;
    for (int i = 0; i < 1060; i++) begin
      sb_q.push_back(model_b(n_b + 1));
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (act_b !== e) begin
        n_fail++;
        $display("FAIL frame_trace n=%0d: got %h, expected %h", n_b, act_b, e);
      end
      if (act_b.fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = n_b;
        else if (fs_second < 0) fs_second = n_b;
      end
      if (!act_b.vs) begin
        if (int'(act_b.v) < vmin) vmin = int'(act_b.v);
        if (int'(act_b.v) > vmax) vmax = int'(act_b.v);
      end
      if (int'(act_b.v) >= B_VD && act_b.von) von_bad++;
    end
    n_checks++;
    if (fs_cnt !== 2 || fs_first !== 527) begin
      n_fail++;
      $display("FAIL frame_start_pulses: got %0d pulses first at %0d, expected 2 first at 527",
               fs_cnt, fs_first);
    end
    n_checks++;
    if (fs_second - fs_first !== 528) begin
      n_fail++;
      $display("FAIL frame_period: got %0d clks, expected 528", fs_second - fs_first);
    end
    n_checks++;
    if (vmin !== 7 || vmax !== 8) begin
      n_fail++;
      $display("FAIL vsync_lines: got %0d..%0d, expected 7..8", vmin, vmax);
    end
    n_checks++;
    if (von_bad !== 0) begin
      n_fail++;
      $display("FAIL video_on_blank_lines: got %0d active clks, expected 0", von_bad);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    bit   found;
    int   first;
    // Full-size instance: reset lands on the tick at (300,1).
    found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      sb_q.push_back(model_a(n_a + 1));
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (act_a !== e) begin
        n_fail++;
        $display("FAIL pre_reset_trace_a n=%0d: got %h, expected %h", n_a, act_a, e);
      end
      if (act_a.tick && act_a.h == 10'd300 && act_a.v == 10'd1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_a_wait: got timeout, expected tick at (300,1)");
    end
    rst_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if (act_a !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset_mid_a: got %h, expected %h", act_a, RST_OBS);
    end
    rst_a = 1'b0;
    first = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (act_a.tick && first < 0) first = n_a;
    end
    n_checks++;
    if (first !== 3) begin
      n_fail++;
      $display("FAIL reset_mid_a_div: got first tick at clk %0d, expected clk 4", first + 1);
    end
    // Scaled instance: reset lands on the tick at (10,4).
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      sb_q.push_back(model_b(n_b + 1));
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (act_b !== e) begin
        n_fail++;
        $display("FAIL pre_reset_trace_b n=%0d: got %h, expected %h", n_b, act_b, e);
      end
      if (act_b.tick && act_b.h == 10'd10 && act_b.v == 10'd4) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_b_wait: got timeout, expected tick at (10,4)");
    end
    rst_b = 1'b1;
    @(negedge clk);
    n_checks++;
    if (act_b !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset_mid_b: got %h, expected %h", act_b, RST_OBS);
    end
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(model_b(n_b + 1));
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (act_b !== e) begin
        n_fail++;
        $display("FAIL post_reset_trace_b n=%0d: got %h, expected %h", n_b, act_b, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_line_scan();
    test_line_wrap();
    test_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
